// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_ctrl_pkg
//  Description : Shared constants for the LED mode controller.
//                - Mode and rate encodings.
//                - The initial LED pattern loaded for each mode.
//                - The mapping from rate code to step period in clock cycles.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

  // Width of the step counter and of the period value.
  localparam int unsigned c_cnt_w = 32;

  // Mode encodings as seen on cmd_mode and mode.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_SHIFT = 2'd3
  } led_mode_t;

  // Rate encodings as seen on cmd_rate.
  localparam logic [1:0] c_rate_div8 = 2'd0;  // P = CLK_FREQ/8
  localparam logic [1:0] c_rate_div4 = 2'd1;  // P = CLK_FREQ/4
  localparam logic [1:0] c_rate_div2 = 2'd2;  // P = CLK_FREQ/2
  localparam logic [1:0] c_rate_div1 = 2'd3;  // P = CLK_FREQ

  // Pattern shown right after a mode is loaded.
  localparam logic [7:0] c_init_off   = 8'h00;
  localparam logic [7:0] c_init_count = 8'h00;
  localparam logic [7:0] c_init_blink = 8'hFF;
  localparam logic [7:0] c_init_shift = 8'h01;

  // SHIFT bounce end points.
  localparam logic [7:0] c_shift_msb = 8'h80;
  localparam logic [7:0] c_shift_lsb = 8'h01;

  function automatic logic [7:0] init_pattern(input led_mode_t m);
    logic [7:0] v;
    case (m)
      MODE_COUNT: v = c_init_count;
      MODE_BLINK: v = c_init_blink;
      MODE_SHIFT: v = c_init_shift;
      default:    v = c_init_off;
    endcase
    return v;
  endfunction

  // Step period in clock cycles for a rate code. CLK_FREQ is a multiple of 8,
  // so every division here is exact.
  function automatic logic [c_cnt_w-1:0] rate_period(input logic [1:0] rate,
                                                     input int unsigned clk_freq);
    logic [c_cnt_w-1:0] v;
    case (rate)
      c_rate_div8: v = clk_freq / 32'd8;
      c_rate_div4: v = clk_freq / 32'd4;
      c_rate_div2: v = clk_freq / 32'd2;
      default:     v = clk_freq;
    endcase
    return v;
  endfunction

endpackage : led_ctrl_pkg
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_tick_gen
//  Description : Step prescaler. Counts enabled cycles from 0 to period-1 and
//                raises tick for the cycle in which the count sits at
//                period-1; the count wraps to 0 on the following edge.
//  Ports       : clk    - clock, rising edge
//                rst    - asynchronous active-high reset
//                clear  - synchronous clear of the count (wins over enable)
//                enable - count advances only while high
//                period - step period in cycles (>= 2)
//                tick   - one-cycle step pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen
  import led_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [c_cnt_w-1:0] period,
  output logic               tick
);

  logic [c_cnt_w-1:0] r_count;
  logic               w_at_end;

  // Unsigned compare against the last count value of the period.
  assign w_at_end = (r_count == (period - 32'd1));

  // Combinational off the count register so the pulse lands in the same
  // cycle the count reaches period-1, and drops to 0 as soon as reset or
  // clear take effect.
  assign tick = enable && !clear && w_at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_at_end ? '0 : (r_count + 32'd1);
    end
  end

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/led_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module      : led_mode_controller
//  Description : Drives an 8-bit LED pattern in one of four modes (OFF,
//                COUNT, BLINK, SHIFT), stepping once every P cycles. A
//                command (mode + rate) is accepted with a valid/ready
//                handshake, latched, and applied one cycle later in LOAD,
//                which restarts the pattern and the step counter.
//  Parameters  : CLK_FREQ  - clock frequency in Hz (multiple of 8, >= 16)
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous active-high reset
//                cmd_valid - command offered
//                cmd_ready - command can be accepted (high in RUN)
//                cmd_mode  - requested mode (0 OFF,1 COUNT,2 BLINK,3 SHIFT)
//                cmd_rate  - requested rate code (period CLK_FREQ/8 .. /1)
//                pause     - freezes stepping while high
//                leds      - registered LED pattern
//                mode      - registered active mode
//                tick      - one-cycle pulse marking each step
//  Revision    : 1.0 - initial release
// ============================================================================
module led_mode_controller
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [1:0] cmd_rate,
  input  logic       pause,
  output logic [7:0] leds,
  output logic [1:0] mode,
  output logic       tick
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t             r_state;
  led_mode_t          r_lat_mode;
  logic [1:0]         r_lat_rate;
  led_mode_t          r_mode;
  logic [c_cnt_w-1:0] r_period;
  logic [7:0]         r_leds;
  logic               r_dir_left;

  logic               w_accept;
  logic               w_load;
  logic               w_step_en;
  logic               w_tick;
  logic [7:0]         w_next_leds;
  logic               w_next_dir_left;

  assign cmd_ready = (r_state == ST_RUN);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_load    = (r_state == ST_LOAD);

  // An accepted command suppresses the step of that cycle, so a command
  // arriving exactly at count P-1 produces neither a tick nor a step.
  assign w_step_en = (r_state == ST_RUN) && (r_mode != MODE_OFF) &&
                     !pause && !w_accept;

  led_tick_gen u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_load),
    .enable (w_step_en),
    .period (r_period),
    .tick   (w_tick)
  );

  // Next pattern for one step in the current mode.
  always_comb begin
    w_next_leds     = r_leds;
    w_next_dir_left = r_dir_left;
    case (r_mode)
      MODE_COUNT: w_next_leds = r_leds + 8'd1;
      MODE_BLINK: w_next_leds = ~r_leds;
      MODE_SHIFT: begin
        // Bounce: turn around at either end instead of wrapping.
        if (r_dir_left) begin
          if (r_leds == c_shift_msb) begin
            w_next_leds     = c_shift_msb >> 1;
            w_next_dir_left = 1'b0;
          end else begin
            w_next_leds = r_leds << 1;
          end
        end else begin
          if (r_leds == c_shift_lsb) begin
            w_next_leds     = c_shift_lsb << 1;
            w_next_dir_left = 1'b1;
          end else begin
            w_next_leds = r_leds >> 1;
          end
        end
      end
      default: begin
        w_next_leds     = r_leds;
        w_next_dir_left = r_dir_left;
      end
    endcase
  end

  // Command FSM and pattern registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_lat_mode <= MODE_OFF;
      r_lat_rate <= c_rate_div8;
      r_mode     <= MODE_OFF;
      r_period   <= rate_period(c_rate_div8, CLK_FREQ);
      r_leds     <= c_init_off;
      r_dir_left <= 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            r_lat_mode <= led_mode_t'(cmd_mode);
            r_lat_rate <= cmd_rate;
            r_state    <= ST_LOAD;
          end else if (w_tick) begin
            r_leds     <= w_next_leds;
            r_dir_left <= w_next_dir_left;
          end
        end
        ST_LOAD: begin
          // The tick generator is cleared in this same cycle.
          r_mode     <= r_lat_mode;
          r_period   <= rate_period(r_lat_rate, CLK_FREQ);
          r_leds     <= init_pattern(r_lat_mode);
          r_dir_left <= 1'b1;
          r_state    <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign leds = r_leds;
  assign mode = r_mode;
  assign tick = w_tick;

endmodule : led_mode_controller
`default_nettype wire

// File: tb/tb_led_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_mode_controller
//  Description : Self-checking bench for led_mode_controller at CLK_FREQ=16
//                (P = 2/4/8/16). The reference model tracks only the number
//                of active (unpaused) cycles since the last load and derives
//                the expected pattern and tick from that count arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_mode_controller;

  localparam int unsigned CLK_FREQ = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_mode = 2'd0;
  logic [1:0] cmd_rate = 2'd0;
  logic       pause = 1'b0;
  logic       cmd_ready;
  logic [7:0] leds;
  logic [1:0] mode;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit m_loading;
  int m_lat_mode;
  int m_lat_rate;
  int m_mode;
  int m_period;
  int m_act;       // active cycles counted since the last load

  bit         seen_wrap;
  logic [7:0] prev_leds;

  led_mode_controller #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_rate  (cmd_rate),
    .pause     (pause),
    .leds      (leds),
    .mode      (mode),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int period_of(input int rate);
    return CLK_FREQ / (8 >> rate);
  endfunction

  // Expected pattern after s = m_act / P completed steps.
  function automatic logic [7:0] exp_leds();
    int s;
    int t;
    int pos;
    s = m_act / m_period;
    case (m_mode)
      1: return 8'(s % 256);
      2: return (s % 2 == 1) ? 8'h00 : 8'hFF;
      3: begin
        t   = s % 14;                  // a full bounce is 14 steps
        pos = (t <= 7) ? t : 14 - t;
        return 8'h01 << pos;
      end
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model_reset();
    m_loading  = 1'b0;
    m_lat_mode = 0;
    m_lat_rate = 0;
    m_mode     = 0;
    m_period   = period_of(0);
    m_act      = 0;
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the
  // model at the rising edge with the same inputs.
  task automatic cycle(input bit v, input int md, input int rt, input bit p);
    bit acc;
    bit exp_tick;
    @(negedge clk);
    cmd_valid = v;
    cmd_mode  = 2'(md);
    cmd_rate  = 2'(rt);
    pause     = p;
    #1;
    acc      = v && !m_loading;
    exp_tick = !m_loading && (m_mode != 0) && !p && !acc &&
               (m_act % m_period == m_period - 1);
    check_eq("ready", 32'(cmd_ready), 32'(!m_loading));
    check_eq("mode",  32'(mode),      32'(m_mode));
    check_eq("leds",  32'(leds),      32'(exp_leds()));
    check_eq("tick",  32'(tick),      32'(exp_tick));
    if (m_mode == 1 && prev_leds == 8'hFF && leds == 8'h00) seen_wrap = 1'b1;
    prev_leds = leds;
    @(posedge clk);
    if (m_loading) begin
      m_mode    = m_lat_mode;
      m_period  = period_of(m_lat_rate);
      m_act     = 0;
      m_loading = 1'b0;
    end else if (v) begin
      m_lat_mode = md;
      m_lat_rate = rt;
      m_loading  = 1'b1;
    end else if (m_mode != 0 && !p) begin
      m_act++;
    end
  endtask

  task automatic idle(input int n, input bit p);
    for (int i = 0; i < n; i++)
      cycle(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), p);
  endtask

  // Assert reset between clock edges and check outputs before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_leds",  32'(leds),      32'h00);
    check_eq("rst_mode",  32'(mode),      32'h0);
    check_eq("rst_ready", 32'(cmd_ready), 32'h1);
    check_eq("rst_tick",  32'(tick),      32'h0);
    model_reset();
    prev_leds = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    model_reset();
    do_reset();
    idle(4, 1'b0);

    // COUNT at rate 1, long enough to wrap 0xFF -> 0x00.
    cycle(1'b1, 1, 1, 1'b0);
    seen_wrap = 1'b0;
    idle(1100, 1'b0);
    check_eq("count_wrap", 32'(seen_wrap), 32'h1);

    // SHIFT at rate 0, several full bounces.
    cycle(1'b1, 3, 0, 1'b0);
    idle(40, 1'b0);

    // Reset in the middle of operation.
    do_reset();

    // BLINK at rate 0 with a 10-cycle pause.
    cycle(1'b1, 2, 0, 1'b0);
    idle(3, 1'b0);
    idle(10, 1'b1);
    idle(6, 1'b0);

    // Collision: command accepted exactly when the count is at P-1.
    cycle(1'b1, 1, 2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!m_loading && m_mode != 0 && (m_act % m_period == m_period - 1)) begin
        found = 1'b1;
        break;
      end
      cycle(1'b0, 0, 0, 1'b0);
    end
    check_eq("collide_wait", 32'(found), 32'h1);
    cycle(1'b1, 3, 1, 1'b0);
    idle(10, 1'b0);

    // Restart with an identical COUNT command once leds reaches 0x05.
    cycle(1'b1, 1, 0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!m_loading && m_mode == 1 && exp_leds() == 8'h05) begin
        found = 1'b1;
        break;
      end
      cycle(1'b0, 0, 0, 1'b0);
    end
    check_eq("restart_wait", 32'(found), 32'h1);
    cycle(1'b1, 1, 0, 1'b0);
    idle(8, 1'b0);

    // Reset while in LOAD, then a command on the first edge after release.
    cycle(1'b1, 3, 3, 1'b0);
    do_reset();
    cycle(1'b1, 2, 1, 1'b0);
    idle(12, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0)
        do_reset();
      else
        cycle($urandom_range(0, 19) == 0, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_led_mode_controller
`default_nettype wire

// File: doc/led_mode_controller.md
LED_MODE_CONTROLLER -- requirements
Module: led_mode_controller

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 25_000_000, meaning the clock frequency in Hz; legal values are multiples of 8, minimum 16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the asynchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit, meaning a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit, meaning the block can accept a command.
REQ-006 The block SHALL have port cmd_mode, input, 2 bits, meaning the requested mode: 0 OFF, 1 COUNT, 2 BLINK, 3 SHIFT.
REQ-007 The block SHALL have port cmd_rate, input, 2 bits, meaning the requested step period P: 0 = CLK_FREQ/8, 1 = CLK_FREQ/4, 2 = CLK_FREQ/2, 3 = CLK_FREQ cycles.
REQ-008 The block SHALL have port pause, input, 1 bit; while high, stepping is frozen.
REQ-009 The block SHALL have port leds, output, 8 bits, the registered LED pattern.
REQ-010 The block SHALL have port mode, output, 2 bits, the currently active mode (registered).
REQ-011 The block SHALL have port tick, output, 1 bit, a one-cycle pulse marking each step.

Function
REQ-012 The FSM SHALL have states RUN and LOAD.
- cmd_ready is 1 in RUN and 0 in LOAD.
REQ-013 A command SHALL be accepted on the edge where cmd_valid && cmd_ready.
- At that edge: cmd_mode and cmd_rate are latched and the FSM goes to LOAD.
REQ-014 On the edge leaving LOAD, the block SHALL do all of the following.
- Set mode to the latched mode and the period to the latched P.
- Clear the tick counter to 0.
- Load leds with the initial pattern: OFF 0x00, COUNT 0x00, BLINK 0xFF, SHIFT 0x01.
- Return the FSM to RUN.
REQ-015 The tick counter SHALL behave as follows in RUN.
- It increments each cycle while mode != OFF and pause = 0.
- When it equals P-1 and pause = 0: tick = 1 that cycle, and at the next edge the counter wraps to 0 and leds steps.
REQ-016 On each step, leds SHALL update by mode.
- COUNT: leds+1 modulo 256 (0xFF -> 0x00).
- BLINK: invert (0xFF <-> 0x00).
- SHIFT: bounce a single set bit 0x01 -> 0x02 -> ... -> 0x80 -> 0x40 -> ... -> 0x01, using an internal direction flag that is set to left on load.
REQ-017 In OFF mode, tick SHALL stay 0, the counter SHALL hold at 0, and leds SHALL hold at 0x00.
REQ-018 While pause = 1, the counter, leds, tick (0) and the direction flag SHALL all hold.
- pause SHALL NOT block command acceptance.
REQ-019 If a command is accepted in the same cycle the counter reaches P-1, the command SHALL win.
- No step occurs, and tick is 0 in that cycle.
REQ-020 A command with the same mode and rate as the active one SHALL still restart the pattern and the counter.
REQ-021 Latency: if a command is accepted at edge k, leds SHALL show the initial pattern after edge k+1.
- The first step, absent pause, is visible after edge k+1+P.
REQ-022 The tick counter SHALL be 32 bits wide, and every comparison SHALL be unsigned.

Reset
REQ-023 Asserting rst SHALL immediately force the following, at any time including during LOAD.
- FSM = RUN, mode = OFF, leds = 0x00, tick = 0, cmd_ready = 1.
- Counter = 0, direction = left, latched command = OFF / rate 0.
REQ-024 After rst is released, the first command SHALL be acceptable on the first rising edge.

Structure
REQ-025 Package led_ctrl_pkg SHALL hold the shared constants.
- Mode encodings and rate encodings.
- The initial patterns for each mode.
- The rate-to-divisor mapping, as a function of CLK_FREQ.
REQ-026 The prescaler SHALL be one sub-module, led_tick_gen.
- Inputs: clk, rst, clear, enable, period.
- Output: tick.
- The FSM and the pattern logic remain in led_mode_controller.

Verification (CLK_FREQ = 16, so P = 2/4/8/16 for rates 0..3)
REQ-027 Reset check: hold rst mid-operation -> leds = 0x00, mode = 0, cmd_ready = 1 and tick = 0 immediately, without waiting for a clock.
REQ-028 COUNT check: accept COUNT at rate 1 -> leds = 0x00, then 0x01 after 4 more cycles, then 0x02 after 4 more.
- Over 1024 cycles, leds wraps 0xFF -> 0x00.
REQ-029 SHIFT check: accept SHIFT at rate 0 -> leds steps every 2 cycles through 0x01, 0x02, ..., 0x80, 0x40, ..., 0x01.
- 14 steps make one full bounce.
REQ-030 Pause check: run BLINK at rate 0 and hold pause for 10 cycles -> leds and the counter hold and no tick occurs.
- After release, the next step comes 2 - (elapsed count) cycles later.
REQ-031 Collision check: accept a command at the same edge the counter reaches P-1 -> no step.
- The new initial pattern appears 1 cycle later, and cmd_ready is 0 for exactly 1 cycle.
REQ-032 Restart check: issue the same COUNT command while leds = 0x05 -> leds returns to 0x00 and the counter restarts.
